// File: rtl/mouse_ps2_pkg.sv
// Shared PS/2 mouse constants: host command bytes, device response bytes and
// the responder state encoding.
package mouse_ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_DISABLE  = 8'hF5;
  localparam logic [7:0] CMD_DEFAULTS = 8'hF6;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_DEV_ID = 8'h00;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ACK_SEND  = 3'd1;
  localparam logic [2:0] ST_ACK_WAIT  = 3'd2;
  localparam logic [2:0] ST_BAT_DELAY = 3'd3;
  localparam logic [2:0] ST_BAT_SEND  = 3'd4;
  localparam logic [2:0] ST_BAT_WAIT  = 3'd5;
  localparam logic [2:0] ST_ID_SEND   = 3'd6;
  localparam logic [2:0] ST_ID_WAIT   = 3'd7;

  function automatic logic is_known_cmd(input logic [7:0] c);
    return (c == CMD_RESET)  || (c == CMD_GET_ID)  || (c == CMD_ENABLE) ||
           (c == CMD_DISABLE) || (c == CMD_DEFAULTS);
  endfunction

endpackage

// File: rtl/mouse_cmd_responder_if.sv
// Byte-level link between the device-side PS/2 rx/tx and the command responder.
// master = host/transceiver side, slave = responder.
interface mouse_cmd_responder_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] tx_data;
  logic       reporting_en;
  logic       busy;

  modport master (
    output rx_data, rx_done_tick, tx_done_tick,
    input  wr_ps2, tx_data, reporting_en, busy
  );

  modport slave (
    input  rx_data, rx_done_tick, tx_done_tick,
    output wr_ps2, tx_data, reporting_en, busy
  );
endinterface

// File: rtl/ps2_delay_timer.sv
// Remaining-cycles down-counter: load arms it, clr zeroes it, done while zero.
module ps2_delay_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/mouse_cmd_responder.sv
// Device-side PS/2 mouse command responder (ACK / BAT / device ID).
// MOUSE_RESEND_EN: answer unrecognised commands with 0xFE instead of 0xFA.
module mouse_cmd_responder
  import mouse_ps2_pkg::*;
#(
  parameter logic [15:0] BAT_DELAY = 16'd50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mouse_cmd_responder_if.slave   bus
);
  localparam int CW = (BAT_DELAY == 16'd0) ? 1 : $clog2(int'(BAT_DELAY) + 1);
  localparam logic [CW-1:0] TMR_INIT = (BAT_DELAY == 16'd0) ? '0 : CW'(BAT_DELAY - 16'd1);

  logic [2:0] state;
  logic [7:0] cmd_q;
  logic [7:0] tx_q;
  logic       rep_q;
  logic [7:0] first_rsp;
  logic       tmr_load;
  logic       tmr_done;

  always_comb begin
`ifdef MOUSE_RESEND_EN
    first_rsp = is_known_cmd(bus.rx_data) ? RSP_ACK : RSP_RESEND;
`else
    first_rsp = RSP_ACK;
`endif
  end

  // Timer holds remaining BAT cycles; armed by the reset command's ACK completing.
  assign tmr_load = !bus.rx_done_tick && (state == ST_ACK_WAIT) &&
                    bus.tx_done_tick && (cmd_q == CMD_RESET);

  ps2_delay_timer #(.W(CW)) u_bat_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.rx_done_tick),
    .load     (tmr_load),
    .load_val (TMR_INIT),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cmd_q <= 8'h00;
      tx_q  <= 8'h00;
      rep_q <= 1'b0;
    end else if (bus.rx_done_tick) begin
      // A new host command always wins: aborts any sequence in flight.
      state <= ST_ACK_SEND;
      cmd_q <= bus.rx_data;
      tx_q  <= first_rsp;
      case (bus.rx_data)
        CMD_ENABLE:                           rep_q <= 1'b1;
        CMD_RESET, CMD_DISABLE, CMD_DEFAULTS: rep_q <= 1'b0;
        default: ;
      endcase
    end else begin
      case (state)
        ST_ACK_SEND: state <= ST_ACK_WAIT;
        ST_ACK_WAIT: if (bus.tx_done_tick) begin
          if (cmd_q == CMD_RESET) begin
            if (BAT_DELAY == 16'd0) begin
              state <= ST_BAT_SEND;
              tx_q  <= RSP_BAT_OK;
            end else begin
              state <= ST_BAT_DELAY;
            end
          end else if (cmd_q == CMD_GET_ID) begin
            state <= ST_ID_SEND;
            tx_q  <= RSP_DEV_ID;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BAT_DELAY: if (tmr_done) begin
          state <= ST_BAT_SEND;
          tx_q  <= RSP_BAT_OK;
        end
        ST_BAT_SEND: state <= ST_BAT_WAIT;
        ST_BAT_WAIT: if (bus.tx_done_tick) begin
          state <= ST_ID_SEND;
          tx_q  <= RSP_DEV_ID;
        end
        ST_ID_SEND:  state <= ST_ID_WAIT;
        ST_ID_WAIT:  if (bus.tx_done_tick) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_ps2       = (state == ST_ACK_SEND) || (state == ST_BAT_SEND) ||
                            (state == ST_ID_SEND);
  assign bus.tx_data      = tx_q;
  assign bus.reporting_en = rep_q;
  assign bus.busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_mouse_cmd_responder.sv
// Self-checking bench for mouse_cmd_responder (BAT_DELAY = 8): vector table,
// randomized commands against a transaction-level model, and corner sequences.
module tb_mouse_cmd_responder;
  localparam logic [15:0] BAT  = 16'd8;
  localparam int          BATI = 8;
`ifdef MOUSE_RESEND_EN
  localparam logic [7:0] UNK_RSP = 8'hFE;
`else
  localparam logic [7:0] UNK_RSP = 8'hFA;
`endif

  typedef struct {
    logic [7:0] cmd;
    int         n;
    logic [7:0] r0, r1, r2;
    logic       rep;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mouse_cmd_responder_if bus();
  mouse_cmd_responder #(.BAT_DELAY(BAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bus.rx_data = c; bus.rx_done_tick = 1'b1;
    tick();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
  endtask

  // Transaction-level model: response list and reporting flag after a command.
  function automatic void model(input logic [7:0] c, input logic rep_in, output int n,
                                output logic [2:0][7:0] rsp, output logic rep_out);
    rsp = '0; rep_out = rep_in;
    case (c)
      8'hFF:        begin n = 3; rsp = {8'h00, 8'hAA, 8'hFA}; rep_out = 1'b0; end
      8'hF2:        begin n = 2; rsp = {8'h00, 8'h00, 8'hFA}; end
      8'hF4:        begin n = 1; rsp[0] = 8'hFA; rep_out = 1'b1; end
      8'hF5, 8'hF6: begin n = 1; rsp[0] = 8'hFA; rep_out = 1'b0; end
      default:      begin n = 1; rsp[0] = UNK_RSP; end
    endcase
  endfunction

  task automatic run_cmd(input logic [7:0] c, input int n, input logic [2:0][7:0] rsp,
                         input logic rep_exp);
    int lat, exp_lat, gap;
    send_cmd(c);
    chk("ack_req", bus.wr_ps2, 1);
    chk("rsp0", bus.tx_data, rsp[0]);
    chk("rep_at_ack", bus.reporting_en, rep_exp);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(1, 3);
      repeat (gap) tick();
      chk("wr_low_wait", bus.wr_ps2, 0);
      pulse_done();
      if (i < n - 1) begin
        exp_lat = (c == 8'hFF && i == 0) ? BATI + 1 : 1;
        lat = 1;
        while (!bus.wr_ps2 && lat < BATI + 20) begin tick(); lat++; end
        chk("latency", lat, exp_lat);
        chk("rsp_next", bus.tx_data, rsp[i+1]);
      end
    end
    chk("busy_end", bus.busy, 0);
    chk("wr_end", bus.wr_ps2, 0);
    chk("rep_end", bus.reporting_en, rep_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic rep_model;
    logic [2:0][7:0] rsp;
    int n, saw;
    logic [7:0] c;

    tbl[0] = '{8'hF4, 1, 8'hFA, 8'h00, 8'h00, 1'b1};
    tbl[1] = '{8'hF5, 1, 8'hFA, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{8'hF4, 1, 8'hFA, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{8'hF2, 2, 8'hFA, 8'h00, 8'h00, 1'b1};
    tbl[4] = '{8'hFF, 3, 8'hFA, 8'hAA, 8'h00, 1'b0};
    tbl[5] = '{8'h3C, 1, UNK_RSP, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{8'hF4, 1, 8'hFA, 8'h00, 8'h00, 1'b1};
    tbl[7] = '{8'h3C, 1, UNK_RSP, 8'h00, 8'h00, 1'b1};
    tbl[8] = '{8'hF6, 1, 8'hFA, 8'h00, 8'h00, 1'b0};

    bus.rx_data = 8'h00; bus.rx_done_tick = 1'b0; bus.tx_done_tick = 1'b0;
    repeat (3) tick();
    chk("rst_wr", bus.wr_ps2, 0);
    chk("rst_tx", bus.tx_data, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rep", bus.reporting_en, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      run_cmd(tbl[i].cmd, tbl[i].n, {tbl[i].r2, tbl[i].r1, tbl[i].r0}, tbl[i].rep);

    // Randomized commands against the model.
    rep_model = 1'b0;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 5))
        0: c = 8'hFF;
        1: c = 8'hF2;
        2: c = 8'hF4;
        3: c = 8'hF5;
        4: c = 8'hF6;
        default: c = 8'($urandom_range(0, 8'hEF));
      endcase
      model(c, rep_model, n, rsp, rep_model);
      run_cmd(c, n, rsp, rep_model);
      repeat ($urandom_range(0, 2)) tick();
    end

    // tx_done_tick while idle is ignored.
    pulse_done();
    chk("idle_done_wr", bus.wr_ps2, 0);
    chk("idle_done_busy", bus.busy, 0);

    // Coincident rx/tx done in ACK_WAIT: new command wins, no ID byte follows.
    run_cmd(8'hF5, 1, {8'h00, 8'h00, 8'hFA}, 1'b0);
    send_cmd(8'hF2);
    chk("coin_ack", bus.wr_ps2, 1);
    tick();
    bus.rx_data = 8'hF4; bus.rx_done_tick = 1'b1; bus.tx_done_tick = 1'b1;
    tick();
    bus.rx_done_tick = 1'b0; bus.tx_done_tick = 1'b0;
    chk("coin_wr", bus.wr_ps2, 1);
    chk("coin_tx", bus.tx_data, 8'hFA);
    chk("coin_rep", bus.reporting_en, 1);
    tick();
    pulse_done();
    saw = 0;
    repeat (5) begin if (bus.wr_ps2) saw++; tick(); end
    chk("coin_no_id", saw, 0);
    chk("coin_busy", bus.busy, 0);

    // Abort during BAT_DELAY: no 0xAA ever issued.
    run_cmd(8'hF5, 1, {8'h00, 8'h00, 8'hFA}, 1'b0);
    send_cmd(8'hFF);
    chk("ab_ack", bus.tx_data, 8'hFA);
    tick();
    pulse_done();
    repeat (3) tick();
    chk("ab_busy_delay", bus.busy, 1);
    chk("ab_wr_delay", bus.wr_ps2, 0);
    send_cmd(8'hF4);
    chk("ab_wr", bus.wr_ps2, 1);
    chk("ab_tx", bus.tx_data, 8'hFA);
    chk("ab_rep", bus.reporting_en, 1);
    tick();
    pulse_done();
    saw = 0;
    repeat (3 * BATI) begin if (bus.wr_ps2) saw++; tick(); end
    chk("ab_no_bat", saw, 0);
    chk("ab_busy", bus.busy, 0);

    // Reset asserted mid-BAT_DELAY.
    send_cmd(8'hFF);
    tick();
    pulse_done();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", bus.wr_ps2, 0);
    chk("mid_rst_tx", bus.tx_data, 8'h00);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rep", bus.reporting_en, 0);
    tick();
    rst_n = 1'b1;
    saw = 0;
    repeat (3 * BATI) begin tick(); if (bus.wr_ps2) saw++; end
    chk("post_rst_quiet", saw, 0);

    // Reset while reporting is enabled and an ACK is outstanding.
    send_cmd(8'hF4);
    chk("pre_rst_rep", bus.reporting_en, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst2_rep", bus.reporting_en, 0);
    chk("rst2_tx", bus.tx_data, 8'h00);
    chk("rst2_busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
